uart_rx: RTL

//   8N1 UART receiver; the receive-side counterpart of the existing uart transmitter.

---
 rtl/uart_rx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, validates the start bit, samples 8 data bits LSB-first
// at mid-bit, checks the stop bit and hands each good byte to a one-entry holding register.
module uart_rx #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       o_valid,
  output logic [7:0] o_data,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int CW = $clog2(CLK_DIV + 1) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic            sync1, rx_s;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [2:0]      idx, idx_nx;
  logic [7:0]      shreg, shreg_nx;
  logic            deliver, ferr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shreg <= shreg_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shreg_nx = shreg;
    deliver  = 1'b0;
    ferr     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          cnt_nx   = '0;
        end
      end
      START: begin
        if (cnt == HALF) begin
          cnt_nx = '0;
          idx_nx = '0;
          // A start bit that is already gone at mid-bit is treated as line noise.
          state_nx = rx_s ? IDLE : DATA;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_nx   = '0;
          shreg_nx = {rx_s, shreg[7:1]};
          idx_nx   = idx + 3'd1;
          if (idx == 3'd7) state_nx = STOP;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_nx = '0;
          if (rx_s) begin
            deliver  = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr     = 1'b1;
            state_nx = BRK;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      BRK: begin
        // Hold off until the line returns high so a break is one error, not many frames.
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake: a byte is transferred on any posedge where o_valid && i_ready; o_data is held
  // stable while o_valid is high, and a delivery in the same cycle as a transfer refills it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= ferr;
      o_overrun   <= deliver && o_valid && !i_ready;
      if (deliver) begin
        if (!o_valid || i_ready) begin
          o_data  <= shreg;
          o_valid <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
